// File: rtl/regfile_scoreboard.sv
// ID-stage register file (2 comb read ports, 1 sync write port) with a per-register pending scoreboard and busy count.
// Optional REGFILE_BYPASS_EN adds same-cycle write-through on the read ports; no backpressure, all inputs accepted every cycle.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  output logic              rs1_ready,
  output logic              rs2_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              regWrite,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count
);

  // Register 0 is not stored at all; it reads as zero and is never pending.
  logic [WIDTH-1:0]    regs_q [1:NUM_REGS-1];
  logic [WIDTH-1:0]    regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] pend_q;
  logic [NUM_REGS-1:1] pend_d;
  logic [ADDR_W:0]     busy_q;
  logic [ADDR_W:0]     busy_d;

  logic wr_en;
  logic alloc_en;

  always_comb begin
    wr_en    = regWrite && (rd_addr != '0) && (int'(rd_addr) < NUM_REGS);
    alloc_en = alloc_valid && (alloc_addr != '0) && (int'(alloc_addr) < NUM_REGS) && !flush;
  end

  // Write clears pending first so a same-address allocation can set it again.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    busy_d = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_en && (rd_addr == ADDR_W'(i))) begin
        regs_d[i] = write_data;
        pend_d[i] = 1'b0;
      end
      if (flush) begin
        pend_d[i] = 1'b0;
      end
      if (alloc_en && (alloc_addr == ADDR_W'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_d = busy_d + (ADDR_W+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  // Address 0 and out-of-range addresses fall through to the zero/ready default.
  always_comb begin
    rs1_data  = '0;
    rs1_ready = 1'b1;
    rs2_data  = '0;
    rs2_ready = 1'b1;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1_addr == ADDR_W'(i)) begin
        rs1_data  = regs_q[i];
        rs1_ready = !pend_q[i];
      end
      if (rs2_addr == ADDR_W'(i)) begin
        rs2_data  = regs_q[i];
        rs2_ready = !pend_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (rs1_addr == rd_addr)) begin
      rs1_data  = write_data;
      rs1_ready = 1'b1;
    end
    if (wr_en && (rs2_addr == rd_addr)) begin
      rs2_data  = write_data;
      rs2_ready = 1'b1;
    end
`else
    // Without bypass, a same-cycle write is only visible after the edge.
`endif
  end

  assign busy_count = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (NUM_REGS=20 so out-of-range addresses exist).
module tb_regfile_scoreboard;
  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 20;
  localparam int ADDR_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr, alloc_addr;
  logic [WIDTH-1:0]  rs1_data, rs2_data, write_data;
  logic              rs1_ready, rs2_ready, regWrite, alloc_valid, flush;
  logic [ADDR_W:0]   busy_count;

  int n_chk = 0;
  int n_err = 0;

  regfile_scoreboard #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rd_addr(rd_addr), .write_data(write_data), .regWrite(regWrite),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .flush(flush), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    regWrite    = 1'b0;
    alloc_valid = 1'b0;
    flush       = 1'b0;
    rd_addr     = '0;
    alloc_addr  = '0;
    write_data  = '0;
  endtask

  task automatic rd1(input int a);
    rs1_addr = ADDR_W'(a);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr = '0;
    rs2_addr = '0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;

    // reset state across every address, including out-of-range ones
    for (int a = 0; a < 32; a++) begin
      rs1_addr = ADDR_W'(a);
      rs2_addr = ADDR_W'(31 - a);
      #1;
      check("rst_rs1_data", rs1_data, 32'h0);
      check("rst_rs1_rdy", {31'b0, rs1_ready}, 32'h1);
      check("rst_rs2_data", rs2_data, 32'h0);
      check("rst_rs2_rdy", {31'b0, rs2_ready}, 32'h1);
    end
    check("rst_busy", {26'b0, busy_count}, 32'd0);

    // alloc x5, then write it two edges later
    alloc_valid = 1'b1; alloc_addr = 5;
    tick();
    idle_inputs();
    rd1(5);
    check("alloc5_rdy", {31'b0, rs1_ready}, 32'h0);
    check("alloc5_busy", {26'b0, busy_count}, 32'd1);
    tick();
    regWrite = 1'b1; rd_addr = 5; write_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    rd1(5);
    check("wr5_data", rs1_data, 32'hDEADBEEF);
    check("wr5_rdy", {31'b0, rs1_ready}, 32'h1);
    check("wr5_busy", {26'b0, busy_count}, 32'd0);

    // x0 write and alloc ignored
    regWrite = 1'b1; rd_addr = 0; write_data = 32'hFFFFFFFF;
    alloc_valid = 1'b1; alloc_addr = 0;
    tick();
    idle_inputs();
    rd1(0);
    check("x0_data", rs1_data, 32'h0);
    check("x0_rdy", {31'b0, rs1_ready}, 32'h1);
    check("x0_busy", {26'b0, busy_count}, 32'd0);

    // same-cycle write and alloc to x7: data lands, alloc wins
    regWrite = 1'b1; rd_addr = 7; write_data = 32'h12;
    alloc_valid = 1'b1; alloc_addr = 7;
    tick();
    idle_inputs();
    rd1(7);
    check("wa7_data", rs1_data, 32'h12);
    check("wa7_rdy", {31'b0, rs1_ready}, 32'h0);
    check("wa7_busy", {26'b0, busy_count}, 32'd1);
    regWrite = 1'b1; rd_addr = 7; write_data = 32'h13;
    tick();
    idle_inputs();
    rd1(7);
    check("w7_clear_rdy", {31'b0, rs1_ready}, 32'h1);
    check("w7_clear_busy", {26'b0, busy_count}, 32'd0);

    // three allocations, then flush with same-cycle alloc x10 and write x4
    alloc_valid = 1'b1; alloc_addr = 3; tick();
    alloc_addr = 4; tick();
    alloc_addr = 9; tick();
    idle_inputs();
    #1;
    check("three_busy", {26'b0, busy_count}, 32'd3);
    flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 10;
    regWrite = 1'b1; rd_addr = 4; write_data = 32'h55;
    tick();
    idle_inputs();
    rs2_addr = 4;
    rd1(10);
    check("flush_busy", {26'b0, busy_count}, 32'd0);
    check("flush_x10_rdy", {31'b0, rs1_ready}, 32'h1);
    check("flush_x4_data", rs2_data, 32'h55);
    check("flush_x4_rdy", {31'b0, rs2_ready}, 32'h1);
    rd1(9);
    check("flush_x9_rdy", {31'b0, rs1_ready}, 32'h1);

    // bypass behaviour on a pending register
    regWrite = 1'b1; rd_addr = 6; write_data = 32'h11; tick();
    idle_inputs();
    alloc_valid = 1'b1; alloc_addr = 6; tick();
    idle_inputs();
    regWrite = 1'b1; rd_addr = 6; write_data = 32'hA5; rs2_addr = 6;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_data", rs2_data, 32'hA5);
    check("byp_rdy", {31'b0, rs2_ready}, 32'h1);
`else
    check("nobyp_data", rs2_data, 32'h11);
    check("nobyp_rdy", {31'b0, rs2_ready}, 32'h0);
`endif
    tick();
    idle_inputs();
    #1;
    check("x6_after_data", rs2_data, 32'hA5);
    check("x6_after_rdy", {31'b0, rs2_ready}, 32'h1);
    check("x6_after_busy", {26'b0, busy_count}, 32'd0);

    // write and alloc to different addresses in one cycle
    regWrite = 1'b1; rd_addr = 2; write_data = 32'h22;
    alloc_valid = 1'b1; alloc_addr = 8;
    tick();
    idle_inputs();
    rs2_addr = 8;
    rd1(2);
    check("diff_x2_data", rs1_data, 32'h22);
    check("diff_x2_rdy", {31'b0, rs1_ready}, 32'h1);
    check("diff_x8_rdy", {31'b0, rs2_ready}, 32'h0);
    check("diff_busy", {26'b0, busy_count}, 32'd1);

    // out-of-range write/alloc ignored; highest legal register writable
    regWrite = 1'b1; rd_addr = 25; write_data = 32'hBAD;
    alloc_valid = 1'b1; alloc_addr = 25;
    tick();
    idle_inputs();
    rd1(25);
    check("oor_data", rs1_data, 32'h0);
    check("oor_rdy", {31'b0, rs1_ready}, 32'h1);
    check("oor_busy", {26'b0, busy_count}, 32'd1);
    regWrite = 1'b1; rd_addr = 19; write_data = 32'h19;
    tick();
    idle_inputs();
    rd1(19);
    check("top_reg_data", rs1_data, 32'h19);

    // fill every register's pending bit, re-allocate one, then flush
    for (int i = 1; i < NUM_REGS; i++) begin
      alloc_valid = 1'b1; alloc_addr = ADDR_W'(i);
      tick();
    end
    idle_inputs();
    #1;
    check("full_busy", {26'b0, busy_count}, 32'd19);
    alloc_valid = 1'b1; alloc_addr = 5;
    tick();
    idle_inputs();
    #1;
    check("realloc_busy", {26'b0, busy_count}, 32'd19);
    flush = 1'b1;
    tick();
    idle_inputs();
    #1;
    check("full_flush_busy", {26'b0, busy_count}, 32'd0);

    // reset mid-operation discards same-cycle work
    alloc_valid = 1'b1; alloc_addr = 3;
    regWrite = 1'b1; rd_addr = 3; write_data = 32'h77;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    rs2_addr = 4;
    rd1(3);
    check("mid_rst_x3_data", rs1_data, 32'h0);
    check("mid_rst_x3_rdy", {31'b0, rs1_ready}, 32'h1);
    check("mid_rst_x4_data", rs2_data, 32'h0);
    check("mid_rst_busy", {26'b0, busy_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the ID stage: two combinational read ports and one synchronous write port.
- Each architectural register carries a pending bit (scoreboard) that the issue logic uses to detect read-after-write hazards on in-flight writes.
- Register 0 is hardwired to zero and is never pending.
- A pipeline flush clears all outstanding pending bits after a redirect.

Parameters:
- WIDTH, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers including the hardwired-zero register 0; legal range 2..32.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rs1_data  output  WIDTH  read port 1 data.
- rs2_data  output  WIDTH  read port 2 data.
- rs1_ready  output  1  high when the rs1 value is valid (not pending, or bypassed).
- rs2_ready  output  1  high when the rs2 value is valid.
- rd_addr  input  ADDR_W  writeback destination address.
- write_data  input  WIDTH  writeback data.
- regWrite  input  1  writeback enable.
- alloc_valid  input  1  issue stage claims a destination register.
- alloc_addr  input  ADDR_W  destination register being claimed.
- flush  input  1  clears all pending bits.
- busy_count  output  ADDR_W+1  number of currently pending registers.

Behaviour:
- Reset: synchronous, active-high; rst has priority over every other input.
  - On a clock edge with rst=1: all registers cleared to 0, all pending bits cleared, busy_count=0.
  - After reset, rsN_data=0 and rsN_ready=1 for every address.
- Reads: combinational, zero latency.
  - Address 0 always returns 0 with ready=1.
  - An address >= NUM_REGS returns 0 with ready=1.
  - Otherwise the port returns the stored value, with ready = !pending[addr].
- Write: occurs on the clock edge when regWrite=1, rd_addr!=0 and rd_addr<NUM_REGS.
  - Stores write_data.
  - Clears pending[rd_addr], unless an allocation to the same address occurs in the same cycle (see below).
  - Writes to address 0 or out-of-range addresses are ignored entirely.
- Allocate: on the clock edge when alloc_valid=1, alloc_addr!=0 and alloc_addr<NUM_REGS, pending[alloc_addr] is set. Allocation of an already-pending register leaves it pending (no count change).
- Simultaneous write and alloc, same address: the allocation wins.
  - Data is written.
  - Pending ends set; it represents the newer in-flight producer.
- Simultaneous write and alloc, different addresses: both take effect.
- Flush: on the clock edge with flush=1, all pending bits are cleared and any same-cycle allocation is ignored.
  - A same-cycle regWrite still commits its data.
  - Register contents are never altered by flush.
- busy_count: registered; equals the population count of the pending bits after each edge.
  - Maximum value is NUM_REGS-1.
  - Never underflows, because clearing a non-pending bit is a no-op.
- Reset mid-operation: any same-cycle write, allocation or flush is discarded; the reset state results.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through bypass): when regWrite=1, rd_addr!=0, rd_addr<NUM_REGS and rsN_addr==rd_addr:
  - rsN_data=write_data in the same cycle;
  - rsN_ready=1, regardless of the pending bit.
- Undefined: reads return only stored state. A same-cycle write becomes visible, and ready rises, in the cycle after the edge.
- Pending and count logic are identical in both builds.

Test Plan:
- Reset then read all addresses -> data=0, ready=1 for every address, busy_count=0.
- alloc x5 at edge 1; rs1_addr=5 -> rs1_ready=0 and busy_count=1 after edge 1. Write x5=0xDEADBEEF at edge 3 -> after edge 3 rs1_data=0xDEADBEEF, rs1_ready=1, busy_count=0.
- Write x0=0xFFFFFFFF and alloc x0 -> reads of x0 return 0, ready=1, busy_count unchanged.
- Same-cycle write x7=0x12 and alloc x7 -> after the edge x7 data=0x12, pending=1, busy_count=1.
- alloc x3, x4, x9 on successive edges (busy_count=3), then flush with same-cycle alloc x10 and write x4=0x55 -> busy_count=0, x10 not pending, x4=0x55.
- Bypass, x6 pending, regWrite x6=0xA5 with rs2_addr=6:
  - with REGFILE_BYPASS_EN, same cycle rs2_data=0xA5 and rs2_ready=1;
  - without it, the old value and ready=0 until after the edge.
